divisor_arbiter: RTL and testbench

- Shares one multicycle signed divider (START/NUM/DEN in, COC/RES/DONE out) between N_REQ requesters.
- Round-robin arbitration; operands are captured on grant.
- Sequences the divider start pulse and detects completion.
- Routes the quotient/remainder back with a one-cycle per-requester valid; DEN=0 is handled locally without using the divider.

---
 rtl/divisor_pkg.sv | 19 +
 rtl/divisor_arbiter_if.sv | 37 +++
 rtl/divisor_rr_picker.sv | 32 +++
 rtl/divisor_arbiter.sv | 119 +++++++++++
 tb/tb_divisor_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/divisor_pkg.sv
// Shared types and constants for the divider-sharing arbiter.
// The state enum and the divide-by-zero quotient live here so every block agrees on them.
package divisor_pkg;

  localparam int DEF_SIZE  = 32;
  localparam int DEF_N_REQ = 4;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    ZERO,
    RESP
  } div_arb_state_t;

  // Quotient reported when a requester divides by zero.
  localparam logic [DEF_SIZE-1:0] DZ_COC = '1;

endpackage

// File: rtl/divisor_arbiter_if.sv
// Requester-side and divider-side signals of the divider arbiter.
// The arbiter uses the slave view; the requesters/divider environment uses the master view.
interface divisor_arbiter_if
  import divisor_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int N_REQ = DEF_N_REQ
);

  logic [N_REQ-1:0]      req;
  logic [N_REQ*SIZE-1:0] req_num;
  logic [N_REQ*SIZE-1:0] req_den;
  logic [N_REQ-1:0]      gnt;
  logic [N_REQ-1:0]      valid;
  logic [SIZE-1:0]       coc;
  logic [SIZE-1:0]       res;
  logic                  dz;
  logic                  busy;

  logic                  div_start;
  logic [SIZE-1:0]       div_num;
  logic [SIZE-1:0]       div_den;
  logic [SIZE-1:0]       div_coc;
  logic [SIZE-1:0]       div_res;
  logic                  div_done;

  modport slave (
    input  req, req_num, req_den, div_coc, div_res, div_done,
    output gnt, valid, coc, res, dz, busy, div_start, div_num, div_den
  );

  modport master (
    output req, req_num, req_den, div_coc, div_res, div_done,
    input  gnt, valid, coc, res, dz, busy, div_start, div_num, div_den
  );

endinterface

// File: rtl/divisor_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Rotates the request vector so ptr lands on bit 0, priority-encodes, then rotates the index back.
module divisor_rr_picker
  import divisor_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] winner
);

  logic [N_REQ-1:0] rot;
  int               first;

  // NOTE: every variable gets a default before any branch, so no path can infer a latch.
  always_comb begin
    rot    = '0;
    first  = 0;
    any    = |req;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[IDX_W'((i + int'(ptr)) % N_REQ)];
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) first = i;
    end
    winner = IDX_W'((first + int'(ptr)) % N_REQ);
  end

endmodule

// File: rtl/divisor_arbiter.sv
// Shares one multicycle signed divider between N_REQ requesters with round-robin grant.
// Division by zero is answered locally (quotient all ones, remainder = dividend) without starting the divider.
module divisor_arbiter
  import divisor_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int N_REQ = DEF_N_REQ
) (
  input logic              clk,
  input logic              rstn,
  divisor_arbiter_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  div_arb_state_t   state, state_nx;
  logic [IDX_W-1:0] ptr, owner, winner;
  logic             any;
  logic [SIZE-1:0]  num_q, den_q, coc_q, res_q;
  logic             dz_q, done_q, done_rise;
  logic [N_REQ-1:0] owner_oh;
  logic [SIZE-1:0]  num_slice [N_REQ];
  logic [SIZE-1:0]  den_slice [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign num_slice[g] = bus.req_num[g*SIZE +: SIZE];
    assign den_slice[g] = bus.req_den[g*SIZE +: SIZE];
  end

  divisor_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req    (bus.req),
    .ptr    (ptr),
    .any    (any),
    .winner (winner)
  );

  // Only a fresh rise completes a job, so a level left high by the previous job is ignored.
  assign done_rise = bus.div_done & ~done_q;
  assign owner_oh  = N_REQ'(1) << owner;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any) state_nx = (den_slice[winner] != '0) ? LAUNCH : ZERO;
      LAUNCH:  state_nx = WAIT;
      WAIT:    if (done_rise) state_nx = RESP;
      ZERO:    state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt       = '0;
    bus.valid     = '0;
    bus.div_start = 1'b0;
    case (state)
      LAUNCH: begin
        bus.gnt       = owner_oh;
        bus.div_start = 1'b1;
      end
      ZERO:    bus.gnt   = owner_oh;
      RESP:    bus.valid = owner_oh;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr    <= '0;
      owner  <= '0;
      num_q  <= '0;
      den_q  <= '0;
      coc_q  <= '0;
      res_q  <= '0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= bus.div_done;
      case (state)
        IDLE: begin
          if (any) begin
            owner <= winner;
            num_q <= num_slice[winner];
            den_q <= den_slice[winner];
          end
        end
        WAIT: begin
          if (done_rise) begin
            coc_q <= bus.div_coc;
            res_q <= bus.div_res;
            dz_q  <= 1'b0;
          end
        end
        ZERO: begin
          coc_q <= {SIZE{&DZ_COC}};
          res_q <= num_q;
          dz_q  <= 1'b1;
        end
        RESP: ptr <= (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.coc     = coc_q;
  assign bus.res     = res_q;
  assign bus.dz      = dz_q;
  assign bus.div_num = num_q;
  assign bus.div_den = den_q;

endmodule

// File: tb/tb_divisor_arbiter.sv
// Scoreboard bench for divisor_arbiter with a behavioural multicycle divider attached.
// Expected service order comes from a round-robin model over request sets; a monitor pops results on VALID.
module tb_divisor_arbiter;

  localparam int SIZE = 32;
  localparam int N    = 4;

  typedef struct {
    int          idx;
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] coc;
    logic [31:0] res;
    logic        dz;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  divisor_arbiter_if #(.SIZE(SIZE), .N_REQ(N)) bus ();

  divisor_arbiter #(.SIZE(SIZE), .N_REQ(N)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int          checks   = 0;
  int          errors   = 0;
  int          m_ptr    = 0;
  int          hold_cnt = 0;
  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] op_num [N];
  logic [31:0] op_den [N];

  for (genvar g = 0; g < N; g++) begin : g_ops
    assign bus.req_num[g*SIZE +: SIZE] = op_num[g];
    assign bus.req_den[g*SIZE +: SIZE] = op_den[g];
  end

  // ---------------- behavioural divider ----------------
  // mode 0: done pulse; 1: done held until next start; 2: held level only dropped one cycle after start
  logic [31:0] m_coc = '0, m_res = '0, m_n = '0, m_d = '0;
  logic        m_done = 1'b0, stray_done = 1'b0, m_clr = 1'b0, m_drop = 1'b0;
  int          m_cnt = 0, m_mode = 0, force_lat = 0;

  assign bus.div_coc  = m_coc;
  assign bus.div_res  = m_res;
  assign bus.div_done = m_done | stray_done;

  always @(negedge clk) begin
    if (!rstn) begin
      m_done = 1'b0; m_cnt = 0; m_clr = 1'b0; m_drop = 1'b0; m_coc = '0; m_res = '0;
    end else begin
      if (m_clr || m_drop) begin
        m_done = 1'b0; m_clr = 1'b0; m_drop = 1'b0;
      end
      if (bus.div_start) begin
        m_n    = bus.div_num;
        m_d    = bus.div_den;
        m_mode = $urandom_range(2, 0);
        m_cnt  = (force_lat > 0) ? force_lat : $urandom_range(6, 2);
        if (m_mode == 2) m_drop = 1'b1;
        else             m_done = 1'b0;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          if (m_d == 0) begin
            m_coc = '0; m_res = '0;
          end else begin
            m_coc = $signed(m_n) / $signed(m_d);
            m_res = $signed(m_n) % $signed(m_d);
          end
          m_done = 1'b1;
          if (m_mode == 0) m_clr = 1'b1;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic exp_t expect_for(input int i);
    exp_t e;
    e.idx = i;
    e.num = op_num[i];
    e.den = op_den[i];
    if (op_den[i] == 0) begin
      e.coc = 32'hFFFF_FFFF;
      e.res = op_num[i];
      e.dz  = 1'b1;
    end else begin
      e.coc = $signed(op_num[i]) / $signed(op_den[i]);
      e.res = $signed(op_num[i]) % $signed(op_den[i]);
      e.dz  = 1'b0;
    end
    return e;
  endfunction

  function automatic int pick(input logic [N-1:0] set, input int p);
    for (int k = 0; k < N; k++) begin
      if (set[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Served requesters leave the set unless held; each service advances the pointer past the winner.
  task automatic push_phase(input logic [N-1:0] mask, input int hold_n);
    logic [N-1:0] s;
    int           w;
    s = mask;
    if (hold_n > 0) begin
      for (int k = 0; k < hold_n; k++) begin
        w = pick(s, m_ptr);
        q.push_back(expect_for(w));
        m_ptr = (w + 1) % N;
      end
    end else begin
      while (s != 0) begin
        w = pick(s, m_ptr);
        q.push_back(expect_for(w));
        s[w] = 1'b0;
        m_ptr = (w + 1) % N;
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.gnt != 0) begin
        if (q.size() == 0) fail("gnt_unexpected");
        else begin
          check("gnt_owner", 32'(bus.gnt), 32'(1) << q[0].idx);
          check("start_on_gnt", 32'(bus.div_start), 32'(q[0].den != 0));
          if (bus.div_start) begin
            check("div_num", bus.div_num, q[0].num);
            check("div_den", bus.div_den, q[0].den);
          end
        end
      end else if (bus.div_start) begin
        fail("start_without_gnt");
      end
      if (bus.valid != 0) begin
        if (q.size() == 0) fail("valid_unexpected");
        else begin
          mon_e = q.pop_front();
          check("valid_owner", 32'(bus.valid), 32'(1) << mon_e.idx);
          check("coc", bus.coc, mon_e.coc);
          check("res", bus.res, mon_e.res);
          check("dz", 32'(bus.dz), 32'(mon_e.dz));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // One cycle on; requesters drop REQ after their GNT unless a held phase is running.
  task automatic step();
    @(negedge clk);
    #1;
    if (bus.gnt != 0) begin
      if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) bus.req = '0;
      end else begin
        bus.req = bus.req & ~bus.gnt;
      end
    end
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget && q.size() != 0; c++) step();
    if (q.size() != 0) begin
      fail("timeout_waiting_valid");
      q.delete();
      bus.req  = '0;
      hold_cnt = 0;
    end
    step();
    check("busy_after_resp", 32'(bus.busy), 32'd0);
  endtask

  task automatic run(input logic [N-1:0] mask, input int hold_n);
    push_phase(mask, hold_n);
    step();
    bus.req  = mask;
    hold_cnt = hold_n;
    drain(300);
  endtask

  task automatic set_op(input int i, input logic [31:0] n, input logic [31:0] d);
    op_num[i] = n;
    op_den[i] = d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
    check({tag, "_gnt"},   32'(bus.gnt), 32'd0);
    check({tag, "_valid"}, 32'(bus.valid), 32'd0);
    check({tag, "_coc"},   bus.coc, 32'd0);
    check({tag, "_res"},   bus.res, 32'd0);
    check({tag, "_dz"},    32'(bus.dz), 32'd0);
    check({tag, "_start"}, 32'(bus.div_start), 32'd0);
    check({tag, "_dnum"},  bus.div_num, 32'd0);
    check({tag, "_dden"},  bus.div_den, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] mask;
    int           r, s, lc;
    logic [31:0]  n, d;

    bus.req = '0;
    for (int i = 0; i < N; i++) set_op(i, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rstn = 1'b1;

    // req0 4/2: GNT and DIV_START for exactly one cycle after the sampling edge
    set_op(0, 32'd4, 32'd2);
    push_phase(4'b0001, 0);
    step();
    bus.req = 4'b0001;
    step();
    check("t1_gnt", 32'(bus.gnt), 32'h1);
    check("t1_start", 32'(bus.div_start), 32'h1);
    step();
    check("t1_gnt_off", 32'(bus.gnt), 32'h0);
    check("t1_start_off", 32'(bus.div_start), 32'h0);
    drain(100);

    // signed combinations through the divider
    set_op(1, 32'd4, -32'sd2);  run(4'b0010, 0);
    set_op(1, -32'sd4, 32'd2);  run(4'b0010, 0);
    set_op(1, -32'sd4, -32'sd2); run(4'b0010, 0);

    // divide by zero: GNT at k+1 without start, VALID at k+2
    set_op(2, 32'd9, 32'd0);
    push_phase(4'b0100, 0);
    step();
    bus.req = 4'b0100;
    step();
    check("dz_gnt", 32'(bus.gnt), 32'h4);
    check("dz_no_start", 32'(bus.div_start), 32'h0);
    step();
    check("dz_valid", 32'(bus.valid), 32'h4);
    drain(100);

    // pointer sits at 3: simultaneous 1010 serves 3 then 1
    set_op(1, 32'd100, 32'd7);
    set_op(3, -32'sd50, 32'd3);
    run(4'b1010, 0);

    // bring pointer back to 0, then all four held for five services: 0,1,2,3,0
    set_op(3, 32'd21, 32'd4);
    run(4'b1000, 0);
    set_op(0, 32'd1000, 32'd3);
    set_op(1, -32'sd1000, 32'd7);
    set_op(2, 32'd12345, -32'sd6);
    set_op(3, -32'sd77, -32'sd5);
    run(4'b1111, 5);

    // randomized request sets and operands
    repeat (30) begin
      mask = 4'($urandom_range(15, 1));
      for (int i = 0; i < N; i++) begin
        n = $urandom;
        if ($urandom_range(3, 0) == 0) n = 32'(int'($urandom_range(200, 0)) - 100);
        r = $urandom_range(9, 0);
        if (r == 0) d = 32'd0;
        else if (r < 5) begin
          s = $urandom_range(20, 1);
          if ($urandom_range(1, 0) == 1) s = -s;
          d = 32'(s);
        end else begin
          d = $urandom;
          if (d == 0) d = 32'd1;
        end
        if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF) d = 32'd1;
        set_op(i, n, d);
      end
      run(mask, 0);
    end

    // reset in WAIT aborts the job; a stray DONE afterwards must not produce VALID
    set_op(1, 32'd100, 32'd7);
    force_lat = 20;
    push_phase(4'b0010, 0);
    step();
    bus.req = 4'b0010;
    lc = 0;
    while (!bus.div_start && lc < 10) begin
      step();
      lc++;
    end
    check("rst_launch_seen", 32'(bus.div_start), 32'h1);
    step();
    step();
    rstn = 1'b0;
    q.delete();
    m_ptr    = 0;
    hold_cnt = 0;
    bus.req  = '0;
    #1;
    check_all_zero("midrst");
    step();
    rstn = 1'b1;
    force_lat = 0;
    step();
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    step();
    step();
    check("stray_busy", 32'(bus.busy), 32'h0);
    check("stray_valid", 32'(bus.valid), 32'h0);
    set_op(0, 32'd8, 32'd4);
    run(4'b0001, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
